// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline results with buffered MDU results,
// with a pending-destination scoreboard. Optional write trace under `define WB_TRACE_EN.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_hold,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] pend_mask,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wd
);
    localparam int         AW    = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [4:0]  r_rd_mem   [FIFO_DEPTH];
    logic [31:0] r_data_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [7:0]  r_starve;
    logic        r_hold, r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wd, r_pend;

    logic        w_empty, w_full, w_pipe_eff, w_pop, w_push;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data, w_pend_nxt;
    logic [7:0]  w_starve_nxt;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head_rd    = r_rd_mem[r_rptr[AW-1:0]];
    assign w_head_data  = r_data_mem[r_rptr[AW-1:0]];
    assign w_pipe_eff   = pipe_valid && (pipe_rd != 5'd0) && !r_hold;
    assign w_pop        = !w_pipe_eff && !w_empty;
    assign w_push       = mdu_valid && !w_full && (mdu_rd != 5'd0);
    assign w_starve_nxt = r_starve + 8'd1;

    // Set wins over clear when an issue targets the register being retired.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_pop)
            w_pend_nxt[w_head_rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            w_pend_nxt[issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr[AW-1:0]]   <= mdu_rd;
            r_data_mem[r_wptr[AW-1:0]] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_waddr  <= 5'd0;
            r_wd     <= 32'd0;
            r_hold   <= 1'b0;
            r_pend   <= 32'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_starve <= 8'd0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_pipe_eff) begin
                r_we    <= 1'b1;
                r_waddr <= pipe_rd;
                r_wd    <= pipe_data;
            end else if (w_pop) begin
                r_we    <= 1'b1;
                r_waddr <= w_head_rd;
                r_wd    <= w_head_data;
            end else begin
                r_we <= 1'b0;
            end
            if (w_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
            // A non-empty, unpopped FIFO means the pipeline took the slot this cycle.
            if (w_empty || w_pop) begin
                r_starve <= 8'd0;
                r_hold   <= 1'b0;
            end else if (w_starve_nxt == LIMIT) begin
                r_starve <= 8'd0;
                r_hold   <= 1'b1;
            end else begin
                r_starve <= w_starve_nxt;
                r_hold   <= 1'b0;
            end
        end
    end

`ifdef WB_TRACE_EN
    logic r_src_mdu;

    always_ff @(posedge clk) begin
        if (rst)
            r_src_mdu <= 1'b0;
        else if (w_pipe_eff)
            r_src_mdu <= 1'b0;
        else if (w_pop)
            r_src_mdu <= 1'b1;
    end

    always @(posedge clk) begin
        if (r_we)
            $display("%0t wb %s x%0h <= %h", $time, r_src_mdu ? "MDU" : "PIPE", r_waddr, r_wd);
    end
`endif

    assign mdu_ready = !w_full;
    assign pipe_hold = r_hold;
    assign pend_mask = r_pend;
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wd        = r_wd;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed + randomized bench for wb_write_arbiter against a queue-based model of the write-port rules.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, mdu_valid, issue_valid;
    logic [4:0]  pipe_rd, mdu_rd, issue_rd;
    logic [31:0] pipe_data, mdu_data;
    logic        pipe_hold, mdu_ready, we;
    logic [31:0] pend_mask, wd;
    logic [4:0]  waddr;

    wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pend_mask(pend_mask),
        .we(we), .waddr(waddr), .wd(wd)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; } res_t;

    // Reference state: results waiting for the port, registers awaiting MDU write,
    // how long the oldest waiting result has been passed over, and expected outputs.
    res_t        q[$];
    logic [31:0] m_pend;
    logic        m_hold, m_we;
    int          m_wait;
    logic [4:0]  m_waddr;
    logic [31:0] m_wd;
    bit          acc;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit   pe, was_empty, popped, rdy;
        res_t e;
        if (rst) begin
            q.delete();
            m_pend = 0; m_hold = 0; m_wait = 0; m_we = 0; m_waddr = 0; m_wd = 0;
            return;
        end
        assert (!(issue_valid && issue_rd != 0 && m_pend[issue_rd])) else begin
            n_err++;
            $error("FAIL illegal_issue observed=x%0d expected=not_pending", issue_rd);
        end
        pe        = pipe_valid && pipe_rd != 0 && !m_hold;
        was_empty = (q.size() == 0);
        rdy       = (q.size() < DEPTH);
        popped    = 0;
        if (pe) begin
            m_we = 1; m_waddr = pipe_rd; m_wd = pipe_data;
        end else if (!was_empty) begin
            e = q.pop_front();
            m_we = 1; m_waddr = e.rd; m_wd = e.data;
            m_pend[e.rd] = 1'b0;
            popped = 1;
        end else begin
            m_we = 0;
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        if (mdu_valid && rdy && mdu_rd != 0) begin
            e.rd = mdu_rd; e.data = mdu_data;
            q.push_back(e);
        end
        if (was_empty || popped) begin
            m_wait = 0; m_hold = 0;
        end else begin
            m_wait++;
            m_hold = (m_wait == LIMIT);
            if (m_hold) m_wait = 0;
        end
    endtask

    task automatic tick();
        chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, q.size() < DEPTH});
        acc = mdu_valid && (q.size() < DEPTH) && !rst;
        model_step();
        @(posedge clk); #1;
        chk("we", {31'b0, we}, {31'b0, m_we});
        chk("waddr", {27'b0, waddr}, {27'b0, m_waddr});
        chk("wd", wd, m_wd);
        chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, m_hold});
        chk("pend_mask", pend_mask, m_pend);
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        int          hold_at[$];
        int          guard;
        logic [4:0]  outq[$];
        logic [4:0]  cand;
        bit          offering;

        // Reset with every input active
        rst = 1;
        pipe_valid = 1; pipe_rd = 5'd9; pipe_data = 32'hDEAD_BEEF;
        mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 32'h1111_2222;
        issue_valid = 1; issue_rd = 5'd6;
        model_step();
        @(posedge clk); #1;
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_hold", {31'b0, pipe_hold}, 32'd0);
        chk("rst_ready", {31'b0, mdu_ready}, 32'd1);
        tick();
        rst = 0;

        // Pipeline-only writes, then x0 as idle
        idle_inputs();
        pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'h0000_00AA;
        tick();
        chk("pipe_wd", wd, 32'h0000_00AA);
        pipe_rd = 5'd0;
        tick();
        chk("pipe_x0_we", {31'b0, we}, 32'd0);

        // Collision between pipeline and MDU result
        pipe_rd = 5'd3; pipe_data = 32'h55;
        issue_valid = 1; issue_rd = 5'd7;
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h1234;
        tick();
        chk("coll_pend7", pend_mask, 32'h80);
        idle_inputs();
        tick();
        chk("coll_mdu_wd", wd, 32'h1234);
        chk("coll_pend_clr", pend_mask, 32'd0);

        // Fill the FIFO behind a busy pipeline; fifth offer must wait
        pipe_valid = 1; pipe_rd = 5'd1;
        for (int i = 0; i < 4; i++) begin
            pipe_data = $urandom;
            mdu_valid = 1; mdu_rd = 5'(10 + i); mdu_data = $urandom;
            tick();
        end
        chk("full_ready", {31'b0, mdu_ready}, 32'd0);
        mdu_rd = 5'd14; mdu_data = 32'hCAFE_0014;
        tick();
        tick();
        pipe_valid = 0;
        guard = 0;
        do begin tick(); guard++; end while (!acc && guard < 10);
        chk("fifth_accepted", {31'b0, acc}, 32'd1);
        mdu_valid = 0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin tick(); guard++; end
        tick();
        chk("drain_empty", {31'b0, mdu_ready}, 32'd1);

        // Starvation: two queued results behind a pipe valid every cycle
        idle_inputs();
        pipe_valid = 1; pipe_rd = 5'd2;
        for (int i = 0; i < 30; i++) begin
            pipe_data = $urandom;
            mdu_valid = (i < 2); mdu_rd = 5'(20 + i); mdu_data = $urandom;
            tick();
            if (pipe_hold) hold_at.push_back(i);
        end
        chk("starve_first", (hold_at.size() > 0) ? hold_at[0] : -1, 32'd8);
        chk("starve_second", (hold_at.size() > 1) ? hold_at[1] : -1, 32'd17);

        // Mid-operation reset
        idle_inputs();
        pipe_valid = 1; pipe_rd = 5'd1;
        for (int i = 0; i < 6; i++) begin
            issue_valid = (i < 3); issue_rd = 5'(7 + i);
            mdu_valid = (i >= 3); mdu_rd = 5'(4 + i); mdu_data = 32'hA000_0000 + i;
            tick();
        end
        chk("mid_pend", pend_mask, 32'h0000_0380);
        rst = 1; idle_inputs();
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_we", {31'b0, we}, 32'd0);
        end

        // Randomized traffic
        offering = 0;
        for (int c = 0; c < 400; c++) begin
            if (offering && acc) offering = 0;
            pipe_valid = ($urandom_range(0, 9) < 7);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data  = $urandom;
            issue_valid = 0; issue_rd = 0;
            if ($urandom_range(0, 3) == 0) begin
                for (int t = 0; t < 8; t++) begin
                    cand = 5'($urandom_range(0, 31));
                    if (cand == 0 || !m_pend[cand]) begin
                        issue_valid = 1; issue_rd = cand;
                        if (cand != 0) outq.push_back(cand);
                        break;
                    end
                end
            end
            if (!offering) begin
                mdu_valid = 0;
                if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
                    int k = $urandom_range(0, outq.size() - 1);
                    mdu_rd = outq[k]; outq.delete(k);
                    mdu_data = $urandom; mdu_valid = 1; offering = 1;
                end else if ($urandom_range(0, 19) == 0) begin
                    mdu_rd = 5'd0; mdu_data = $urandom; mdu_valid = 1; offering = 1;
                end
            end
            rst = ($urandom_range(0, 149) == 0);
            if (rst) begin
                outq.delete(); offering = 0; mdu_valid = 0;
                issue_valid = 0;
            end
            tick();
            rst = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the integer register file write port (we/waddr/wd).
- Merges two result sources into one registered write per cycle:
  - the in-order MEM/WB pipeline result;
  - out-of-order results from the multi-cycle mul/div unit (MDU), which are buffered in a small FIFO.
- Keeps a pending-destination scoreboard for in-flight MDU ops, used by ID-stage hazard detection.
- Outputs are registered on posedge clk so the register file captures them on the following negedge.

Parameters:
- FIFO_DEPTH, 4, MDU result buffer entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be blocked by the pipeline before a bubble is forced; range 1..255.

Ports:
- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- pipe_valid  in  1  pipeline result valid this cycle
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- pipe_hold  out  1  registered; upstream must present a bubble while high
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; transfer occurs when mdu_valid & mdu_ready
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- issue_valid  in  1  an MDU op has been issued this cycle
- issue_rd  in  5  destination of the issued MDU op
- pend_mask  out  32  bit i = 1 while an MDU write to xi is outstanding
- we  out  1  register file write enable
- waddr  out  5  register file write address
- wd  out  32  register file write data

Behaviour:
- Reset (rst=1 at posedge):
  - we=0, waddr=0, wd=0, pipe_hold=0, pend_mask=0.
  - FIFO emptied; starvation counter cleared.
  - An MDU entry in flight is discarded, mid-operation included.
- mdu_ready = !fifo_full. This is combinational from FIFO state only, with no dependency on mdu_valid.
- A pipeline write is effective when pipe_valid=1, pipe_rd!=0 and pipe_hold=0. The pipeline is never back-pressured except through pipe_hold.
- Per-cycle selection (result registered into we/waddr/wd at posedge, latency 1):
  1. Effective pipeline write → we=1, waddr=pipe_rd, wd=pipe_data. FIFO is not popped.
  2. Otherwise, FIFO non-empty → pop the head; we=1, waddr=head.rd, wd=head.data.
  3. Otherwise → we=0. waddr/wd hold their previous values.
- x0 handling:
  - MDU results with mdu_rd=0 are accepted (handshake completes) but not enqueued.
  - pipe_rd=0 counts as idle, which frees the slot for the FIFO.
- Simultaneous push and pop:
  - Both are allowed in the same cycle; occupancy is unchanged.
  - When the FIFO is full, a same-cycle pop does NOT raise mdu_ready.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are distinguished by the MSB.
- Starvation counter:
  - Increments on each cycle the FIFO is non-empty and an effective pipeline write wins the slot.
  - Resets to 0 on a pop or when the FIFO is empty.
  - When it reaches STARVE_LIMIT, pipe_hold is driven to 1 for exactly one cycle; the counter clears on that same posedge.
  - While pipe_hold=1, pipe_valid is ignored and the FIFO head is written.
- Scoreboard:
  - On issue_valid with issue_rd!=0, set pend_mask[issue_rd].
  - Clear pend_mask[head.rd] when that entry is popped to the write port.
  - Same-cycle set and clear of the same bit: set wins.
  - Issuing to a register whose bit is already set is illegal; the bench flags it with an assertion.
- pend_mask is registered with 1-cycle latency. It never has bit 0 set.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: on each posedge where we=1, $display prints the simulation time, the source (PIPE or MDU), waddr and wd in hex.
- Undefined: no display code is compiled and there is no functional difference.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs active → we=0, pend_mask=0, mdu_ready=1, pipe_hold=0 after the first posedge.
- Pipeline only: pipe_valid=1, rd=5, data=0x0000_00AA → next cycle we=1, waddr=5, wd=0xAA. Then rd=0 → we=0.
- Collision: issue rd=7 → pend_mask[7]=1. Same cycle: MDU result rd=7 data=0x1234 and pipe rd=3 data=0x55.
  - Cycle+1: write x3=0x55.
  - Cycle+2, with the pipe idle: write x7=0x1234 and pend_mask[7] clears.
- Full FIFO: push 4 MDU results while the pipeline is continuously valid → mdu_ready=0 after the 4th push; a 5th mdu_valid is held, not lost.
- Starvation: FIFO non-empty with the pipe valid every cycle → pipe_hold=1 in the cycle after the 8th blocked cycle, the head is written that cycle, and the counter restarts.
- Mid-operation reset: 3 FIFO entries and pend_mask=0x0000_0380, then rst for 1 cycle → FIFO empty, pend_mask=0, and no stale writes afterwards.
